alu_arbiter: RTL and testbench

//   Shares the single combinational ALU between two requesters (Req0, Req1).

---
 rtl/alu_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters. Requests are
//   accepted one at a time over a valid/ready handshake with round-robin
//   priority. An accepted operation is issued to the ALU for exactly one
//   cycle, and its result is then returned on a shared response channel
//   tagged with the owning requester's ID.
//
// Ports
//   Clk, Reset                 rising-edge clock, synchronous active-high reset
//   Req0_* / Req1_*            Valid (in), Ready (out), Op (in, 2b), A, B (in)
//                              Op: 0=ADD 1=SUB 2=MUL 3=PASS (PASS returns B)
//   Rsp_Valid/Ready/Id/Data    result channel toward the consumer
//   Alu_Add/Sub/Mul/Pass       one-hot ALU op strobes, high only while issuing
//   Reg1_Out, Reg2_Out         ALU operands, held between operations
//   Alu_Out                    combinational ALU result
// ---------------------------------------------------------------------------

// Run-time invariant checks for the arbiter; carries no design logic.
module alu_arbiter_checker (
  input logic       Clk,
  input logic       Reset,
  input logic       in_issue,
  input logic       ready0,
  input logic       ready1,
  input logic [3:0] strobes
);

  // Sample the invariants once per cycle while out of reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      assert ($countones(strobes) <= 1)
        else $error("alu_arbiter: more than one ALU strobe active");
      assert (!(ready0 && ready1))
        else $error("alu_arbiter: both requesters granted");
      assert (in_issue || (strobes == 4'b0000))
        else $error("alu_arbiter: ALU strobe outside issue phase");
    end
  end

endmodule

module alu_arbiter #(
  parameter int DATA_WIDTH = 21
) (
  input  logic                  Clk,
  input  logic                  Reset,

  input  logic                  Req0_Valid,
  output logic                  Req0_Ready,
  input  logic [1:0]            Req0_Op,
  input  logic [DATA_WIDTH-1:0] Req0_A,
  input  logic [DATA_WIDTH-1:0] Req0_B,

  input  logic                  Req1_Valid,
  output logic                  Req1_Ready,
  input  logic [1:0]            Req1_Op,
  input  logic [DATA_WIDTH-1:0] Req1_A,
  input  logic [DATA_WIDTH-1:0] Req1_B,

  output logic                  Rsp_Valid,
  input  logic                  Rsp_Ready,
  output logic                  Rsp_Id,
  output logic [DATA_WIDTH-1:0] Rsp_Data,

  output logic                  Alu_Add,
  output logic                  Alu_Sub,
  output logic                  Alu_Mul,
  output logic                  Alu_Pass,
  output logic [DATA_WIDTH-1:0] Reg1_Out,
  output logic [DATA_WIDTH-1:0] Reg2_Out,
  input  logic [DATA_WIDTH-1:0] Alu_Out
);

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_PASS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                  state;
  logic                    prio;        // side that wins a tie in IDLE
  logic                    id_r;        // owner of the operation in flight
  logic [3:0]              strobe_r;    // {Pass, Mul, Sub, Add}

  logic                    grant_valid;
  logic                    grant;
  logic [1:0]              sel_op;
  logic [DATA_WIDTH-1:0]   sel_a;
  logic [DATA_WIDTH-1:0]   sel_b;

  // Map an opcode to its one-hot strobe vector {Pass, Mul, Sub, Add}.
  function automatic logic [3:0] op_strobes(input logic [1:0] op);
    logic [3:0] s;
    case (op)
      OP_ADD:  s = 4'b0001;
      OP_SUB:  s = 4'b0010;
      OP_MUL:  s = 4'b0100;
      OP_PASS: s = 4'b1000;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Round-robin grant: the priority side wins if valid, otherwise the other.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (state == ST_IDLE) begin
      if (prio == 1'b0) begin
        if (Req0_Valid) begin
          grant_valid = 1'b1;
          grant       = 1'b0;
        end else if (Req1_Valid) begin
          grant_valid = 1'b1;
          grant       = 1'b1;
        end else begin
          grant_valid = 1'b0;
          grant       = 1'b0;
        end
      end else begin
        if (Req1_Valid) begin
          grant_valid = 1'b1;
          grant       = 1'b1;
        end else if (Req0_Valid) begin
          grant_valid = 1'b1;
          grant       = 1'b0;
        end else begin
          grant_valid = 1'b0;
          grant       = 1'b0;
        end
      end
    end else begin
      grant_valid = 1'b0;
      grant       = 1'b0;
    end
  end

  // Operand/opcode mux for the granted requester.
  always_comb begin
    sel_op = 2'd0;
    sel_a  = '0;
    sel_b  = '0;
    if (grant) begin
      sel_op = Req1_Op;
      sel_a  = Req1_A;
      sel_b  = Req1_B;
    end else begin
      sel_op = Req0_Op;
      sel_a  = Req0_A;
      sel_b  = Req0_B;
    end
  end

  // Ready is combinational so a request is accepted in the cycle it is seen.
  assign Req0_Ready = grant_valid & ~grant;
  assign Req1_Ready = grant_valid &  grant;

  assign Alu_Add  = strobe_r[0];
  assign Alu_Sub  = strobe_r[1];
  assign Alu_Mul  = strobe_r[2];
  assign Alu_Pass = strobe_r[3];

  // Arbiter FSM with all outputs registered. Operands and strobes are loaded
  // on the accept edge so they are already valid during the ISSUE cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      prio      <= 1'b0;
      id_r      <= 1'b0;
      strobe_r  <= 4'b0000;
      Reg1_Out  <= '0;
      Reg2_Out  <= '0;
      Rsp_Valid <= 1'b0;
      Rsp_Id    <= 1'b0;
      Rsp_Data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            id_r     <= grant;
            prio     <= ~grant;
            Reg1_Out <= sel_a;
            Reg2_Out <= sel_b;
            strobe_r <= op_strobes(sel_op);
            state    <= ST_ISSUE;
          end else begin
            state    <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // ALU result is valid for the whole issue cycle; capture at its end.
          Rsp_Data  <= Alu_Out;
          Rsp_Id    <= id_r;
          Rsp_Valid <= 1'b1;
          strobe_r  <= 4'b0000;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (Rsp_Ready) begin
            Rsp_Valid <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            state     <= ST_RESP;
          end
        end
        default: begin
          strobe_r  <= 4'b0000;
          Rsp_Valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  alu_arbiter_checker u_checker (
    .Clk      (Clk),
    .Reset    (Reset),
    .in_issue (state == ST_ISSUE),
    .ready0   (Req0_Ready),
    .ready1   (Req1_Ready),
    .strobes  (strobe_r)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter. A transaction-level model (one
//   operation in flight, tracked by cycles since acceptance) predicts every
//   DUT output each cycle. Directed scenarios pin results to hand-computed
//   values; a long randomized run follows.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int DW = 21;
  localparam logic [DW-1:0] MASK = {DW{1'b1}};

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Req0_Valid, Req0_Ready, Req1_Valid, Req1_Ready;
  logic [1:0]    Req0_Op, Req1_Op;
  logic [DW-1:0] Req0_A, Req0_B, Req1_A, Req1_B;
  logic          Rsp_Valid, Rsp_Ready, Rsp_Id;
  logic [DW-1:0] Rsp_Data;
  logic          Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass;
  logic [DW-1:0] Reg1_Out, Reg2_Out, Alu_Out;

  // Requester drive state
  logic          r_valid [2];
  logic [1:0]    r_op    [2];
  logic [DW-1:0] r_a     [2];
  logic [DW-1:0] r_b     [2];
  bit            acc     [2];

  assign Req0_Valid = r_valid[0];
  assign Req0_Op    = r_op[0];
  assign Req0_A     = r_a[0];
  assign Req0_B     = r_b[0];
  assign Req1_Valid = r_valid[1];
  assign Req1_Op    = r_op[1];
  assign Req1_A     = r_a[1];
  assign Req1_B     = r_b[1];

  always #5 Clk = ~Clk;

  alu_arbiter #(.DATA_WIDTH(DW)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_Op(Req0_Op),
    .Req0_A(Req0_A), .Req0_B(Req0_B),
    .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_Op(Req1_Op),
    .Req1_A(Req1_A), .Req1_B(Req1_B),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Id(Rsp_Id),
    .Rsp_Data(Rsp_Data),
    .Alu_Add(Alu_Add), .Alu_Sub(Alu_Sub), .Alu_Mul(Alu_Mul), .Alu_Pass(Alu_Pass),
    .Reg1_Out(Reg1_Out), .Reg2_Out(Reg2_Out), .Alu_Out(Alu_Out)
  );

  // Stand-in ALU; with no strobe it returns a junk value so a mistimed
  // capture shows up as wrong data.
  always_comb begin
    if (Alu_Add)       Alu_Out = Reg1_Out + Reg2_Out;
    else if (Alu_Sub)  Alu_Out = Reg1_Out - Reg2_Out;
    else if (Alu_Mul)  Alu_Out = Reg1_Out * Reg2_Out;
    else if (Alu_Pass) Alu_Out = Reg2_Out;
    else               Alu_Out = Reg1_Out ^ Reg2_Out ^ 21'h0A5A5;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: at most one operation in flight
  bit            m_busy;
  int            m_age;     // cycles since acceptance
  bit            m_prio;
  logic          m_id;
  logic [1:0]    m_op;
  logic [DW-1:0] m_a, m_b, m_reg1, m_reg2;

  // Observations recorded when the model sees a response taken
  bit            got_rsp;
  logic          got_id;
  logic [DW-1:0] got_data;
  logic          last_r0, last_r1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_result(input logic [1:0] op,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    longint m;
    longint x;
    m = longint'(1) << DW;
    case (op)
      2'd0:    x = (longint'(a) + longint'(b)) % m;
      2'd1:    x = (longint'(a) - longint'(b) + m) % m;
      2'd2:    x = (longint'(a) * longint'(b)) % m;
      default: x = longint'(b);
    endcase
    return DW'(x);
  endfunction

  // One clock cycle: compare at negedge+1 against the model, advance the
  // model for the coming posedge, return just after that posedge.
  task automatic step();
    bit         idle, issue, resp, e_r0, e_r1;
    logic [3:0] e_str;
    @(negedge Clk);
    #1;
    idle  = !m_busy;
    issue = m_busy && (m_age == 1);
    resp  = m_busy && (m_age >= 2);
    e_r0  = idle && r_valid[0] && (!m_prio || !r_valid[1]);
    e_r1  = idle && r_valid[1] && ( m_prio || !r_valid[0]);
    e_str = issue ? (4'b0001 << m_op) : 4'b0000;
    last_r0 = Req0_Ready;
    last_r1 = Req1_Ready;

    check("req0_ready", 32'(Req0_Ready), 32'(e_r0));
    check("req1_ready", 32'(Req1_Ready), 32'(e_r1));
    check("both_ready", 32'(Req0_Ready & Req1_Ready), 32'd0);
    check("alu_strobes", 32'({Alu_Pass, Alu_Mul, Alu_Sub, Alu_Add}), 32'(e_str));
    check("reg1_out", 32'(Reg1_Out), 32'(m_reg1));
    check("reg2_out", 32'(Reg2_Out), 32'(m_reg2));
    check("rsp_valid", 32'(Rsp_Valid), 32'(resp));
    if (resp) begin
      check("rsp_id", 32'(Rsp_Id), 32'(m_id));
      check("rsp_data", 32'(Rsp_Data), 32'(ref_result(m_op, m_a, m_b)));
    end

    acc[0] = 1'b0;
    acc[1] = 1'b0;
    if (Reset) begin
      m_busy = 1'b0;
      m_prio = 1'b0;
      m_reg1 = '0;
      m_reg2 = '0;
    end else if (idle) begin
      if (e_r0 || e_r1) begin
        m_id   = e_r1;
        m_op   = r_op[e_r1];
        m_a    = r_a[e_r1];
        m_b    = r_b[e_r1];
        m_reg1 = m_a;
        m_reg2 = m_b;
        m_prio = !e_r1;
        m_busy = 1'b1;
        m_age  = 1;
        acc[e_r1] = 1'b1;
      end
    end else if (issue) begin
      m_age = 2;
    end else if (Rsp_Ready) begin
      m_busy   = 1'b0;
      got_rsp  = 1'b1;
      got_id   = Rsp_Id;
      got_data = Rsp_Data;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  // Issue one request on a side (other side idle), then drop Valid.
  task automatic do_req(input int side, input logic [1:0] op,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n;
    r_valid[side]   = 1'b1;
    r_op[side]      = op;
    r_a[side]       = a;
    r_b[side]       = b;
    r_valid[1-side] = 1'b0;
    got_rsp = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc[side] && n < 8);
    r_valid[side] = 1'b0;
    if (!acc[side]) timeout_fail("accept");
  endtask

  task automatic wait_rsp(input int budget);
    int n;
    n = 0;
    while (!got_rsp && n < budget) begin
      step();
      n++;
    end
    if (!got_rsp) timeout_fail("response");
  endtask

  function automatic logic [DW-1:0] rand_operand();
    int unsigned k;
    k = $urandom_range(0, 7);
    if (k == 0)      return '0;
    else if (k == 1) return MASK;
    else if (k == 2) return DW'($urandom_range(0, 15));
    else             return DW'($urandom());
  endfunction

  logic          q_id   [$];
  logic [DW-1:0] q_data [$];

  initial begin
    for (int s = 0; s < 2; s++) begin
      r_valid[s] = 1'b0;
      r_op[s]    = 2'd0;
      r_a[s]     = '0;
      r_b[s]     = '0;
      acc[s]     = 1'b0;
    end
    Reset     = 1'b1;
    Rsp_Ready = 1'b1;
    m_busy = 1'b0; m_age = 0; m_prio = 1'b0; m_id = 1'b0; m_op = 2'd0;
    m_a = '0; m_b = '0; m_reg1 = '0; m_reg2 = '0;
    got_rsp = 1'b0; got_id = 1'b0; got_data = '0;
    repeat (2) @(posedge Clk);
    #1;
    step();                              // reset-state outputs under Reset
    check("reset_rsp_valid", 32'(Rsp_Valid), 32'd0);
    Reset = 1'b0;

    // 1: Req0 ADD 5+7
    do_req(0, 2'd0, 21'd5, 21'd7);
    wait_rsp(8);
    check("t1_id", 32'(got_id), 32'd0);
    check("t1_data", 32'(got_data), 32'd12);

    // 2: Req1 SUB 3-10 wraps
    do_req(1, 2'd1, 21'd3, 21'd10);
    wait_rsp(8);
    check("t2_id", 32'(got_id), 32'd1);
    check("t2_data", 32'(got_data), 32'd2097145);

    // 3: both valid right after reset -> 0,1,0,1
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    r_valid[0] = 1'b1; r_op[0] = 2'd2; r_a[0] = 21'd6; r_b[0] = 21'd9;
    r_valid[1] = 1'b1; r_op[1] = 2'd3; r_a[1] = 21'd0; r_b[1] = 21'd100;
    got_rsp = 1'b0;
    for (int n = 0; n < 40 && q_id.size() < 4; n++) begin
      step();
      if (got_rsp) begin
        q_id.push_back(got_id);
        q_data.push_back(got_data);
        got_rsp = 1'b0;
      end
    end
    check("t3_count", 32'(q_id.size()), 32'd4);
    for (int i = 0; i < q_id.size(); i++) begin
      check("t3_order", 32'(q_id[i]), 32'(i % 2));
      check("t3_data", 32'(q_data[i]), (i % 2 == 1) ? 32'd100 : 32'd54);
    end
    r_valid[0] = 1'b0;
    r_valid[1] = 1'b0;
    step();

    // 4: consumer stalls 4 cycles in RESP while both requesters wait
    Rsp_Ready = 1'b0;
    do_req(0, 2'd0, 21'd1, 21'd2);
    step();                              // ISSUE
    r_valid[0] = 1'b1; r_valid[1] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      check("t4_hold_valid", 32'(Rsp_Valid), 32'd1);
      check("t4_hold_data", 32'(Rsp_Data), 32'd3);
      check("t4_no_ready", 32'({last_r1, last_r0}), 32'd0);
    end
    Rsp_Ready = 1'b1;
    r_valid[0] = 1'b0; r_valid[1] = 1'b0;
    step();

    // 5a: reset during ISSUE; 5b: reset during stalled RESP
    for (int k = 0; k < 2; k++) begin
      Rsp_Ready = 1'b0;
      do_req(1, 2'd2, 21'd7, 21'd8);
      if (k == 1) step();                // advance into RESP
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      Rsp_Ready = 1'b1;
      r_valid[0] = 1'b1; r_valid[1] = 1'b1;
      step();
      check("t5_grant0", 32'({last_r1, last_r0}), 32'd1);
      r_valid[0] = 1'b0; r_valid[1] = 1'b0;
      got_rsp = 1'b0;
      wait_rsp(8);
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int s = 0; s < 2; s++) begin
        if (r_valid[s] && !acc[s]) begin
          if ($urandom_range(0, 7) == 0) r_valid[s] = 1'b0;
        end else begin
          r_valid[s] = ($urandom_range(0, 2) != 0);
          r_op[s]    = 2'($urandom_range(0, 3));
          r_a[s]     = rand_operand();
          r_b[s]     = rand_operand();
        end
      end
      Rsp_Ready = ($urandom_range(0, 9) < 7);
      Reset     = ($urandom_range(0, 199) == 0);
      step();
    end
    Reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
